// File: rtl/canv_layer_mix_pkg.sv
// Shared constants and types for the canvas layer mixer and its pixel unpacker.
//   - bpp codes (BPP_1..BPP_8), pixel-ID width for a 32-bit vram word,
//     maximum layer count, widest raw colour index, per-layer config struct.
//   - bpp_val_mask(): mask selecting the valid raw index bits for a bpp code.
package canv_layer_mix_pkg;

    localparam logic [1:0] BPP_1 = 2'd0;
    localparam logic [1:0] BPP_2 = 2'd1;
    localparam logic [1:0] BPP_4 = 2'd2;
    localparam logic [1:0] BPP_8 = 2'd3;

    localparam int unsigned WORD_BITS  = 32;
    localparam int unsigned PIX_IDW    = $clog2(WORD_BITS);
    localparam int unsigned MAX_LAYERS = 4;
    localparam int unsigned RAW_W      = 8;

    typedef struct packed {
        logic       en;
        logic [1:0] bpp;
        logic       trans_en;
    } layer_cfg_t;

    localparam layer_cfg_t CFG_RESET = '{en: 1'b0, bpp: BPP_4, trans_en: 1'b0};

    function automatic logic [RAW_W-1:0] bpp_val_mask(input logic [1:0] bpp);
        logic [RAW_W-1:0] m;
        case (bpp)
            BPP_1:   m = 8'h01;
            BPP_2:   m = 8'h03;
            BPP_4:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/canv_pix_unpack.sv
// Registered pixel unpacker: extracts one colour index from a vram word.
//   clk, rst  : clock, synchronous active-high reset
//   word      : vram word holding several packed pixels
//   pix_id    : pixel number within the word (aliased to the pixels per word)
//   bpp       : bpp code (0=1bpp .. 3=8bpp)
//   raw       : extracted index, zero-extended, one cycle after the inputs
module canv_pix_unpack
    import canv_layer_mix_pkg::*;
#(
    parameter int unsigned WORD = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD-1:0]    word,
    input  logic [PIX_IDW-1:0] pix_id,
    input  logic [1:0]         bpp,
    output logic [RAW_W-1:0]   raw
);

    logic [PIX_IDW-1:0] id_mask;
    logic [PIX_IDW-1:0] id_eff;
    logic [PIX_IDW-1:0] shamt;
    logic [RAW_W-1:0]   raw_d;
    logic [RAW_W-1:0]   raw_q;

    always_comb begin
        // pixels per word = 32 >> bpp, so the ID mask is all-ones shifted the same way
        id_mask = {PIX_IDW{1'b1}} >> bpp;
        id_eff  = pix_id & id_mask;
        // id_eff < ppw, so id_eff << bpp always stays inside the word
        shamt   = id_eff << bpp;
        raw_d   = RAW_W'(word >> shamt) & bpp_val_mask(bpp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q <= '0;
        end else begin
            raw_q <= raw_d;
        end
    end

    assign raw = raw_q;

endmodule

// File: rtl/canv_layer_mix.sv
// Multi-layer canvas pixel unpacker and priority mixer (clk_pix domain).
//   clk_pix, rst_pix : pixel clock, synchronous active-high reset
//   frame_start      : commits pending layer config to the active set
//   cfg_we/cfg_layer : write pending config of one layer (out-of-range ignored)
//   cfg_en/bpp/trans_en/trans/offs : per-layer config fields
//   pix_id, paint    : per-layer agu outputs, delayed VRAM_LAT to meet vram_dout
//   vram_dout        : per-layer vram words
//   mix_cidx/mix_paint/mix_layer : frontmost opaque layer's CLUT index
module canv_layer_mix
    import canv_layer_mix_pkg::*;
#(
    parameter int unsigned LAYERS     = 2,
    parameter int unsigned WORD       = 32,
    parameter int unsigned CIDX_ADDRW = 8,
    parameter int unsigned VRAM_LAT   = 2
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic                    frame_start,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_layer,
    input  logic                    cfg_en,
    input  logic [1:0]              cfg_bpp,
    input  logic                    cfg_trans_en,
    input  logic [CIDX_ADDRW-1:0]   cfg_trans,
    input  logic [CIDX_ADDRW-1:0]   cfg_offs,
    input  logic [LAYERS*5-1:0]     pix_id,
    input  logic [LAYERS-1:0]       paint,
    input  logic [LAYERS*WORD-1:0]  vram_dout,
    output logic [CIDX_ADDRW-1:0]   mix_cidx,
    output logic                    mix_paint,
    output logic [1:0]              mix_layer
);

    localparam int unsigned CMP_W = (CIDX_ADDRW > RAW_W) ? CIDX_ADDRW : RAW_W;

    // ---------------- config registers (pending / active) ----------------
    layer_cfg_t            pend_cfg_d   [LAYERS];
    layer_cfg_t            pend_cfg_q   [LAYERS];
    logic [CIDX_ADDRW-1:0] pend_trans_d [LAYERS];
    logic [CIDX_ADDRW-1:0] pend_trans_q [LAYERS];
    logic [CIDX_ADDRW-1:0] pend_offs_d  [LAYERS];
    logic [CIDX_ADDRW-1:0] pend_offs_q  [LAYERS];
    layer_cfg_t            act_cfg_d    [LAYERS];
    layer_cfg_t            act_cfg_q    [LAYERS];
    logic [CIDX_ADDRW-1:0] act_trans_d  [LAYERS];
    logic [CIDX_ADDRW-1:0] act_trans_q  [LAYERS];
    logic [CIDX_ADDRW-1:0] act_offs_d   [LAYERS];
    logic [CIDX_ADDRW-1:0] act_offs_q   [LAYERS];

    always_comb begin
        pend_cfg_d   = pend_cfg_q;
        pend_trans_d = pend_trans_q;
        pend_offs_d  = pend_offs_q;
        for (int unsigned l = 0; l < LAYERS; l++) begin
            if (cfg_we && (cfg_layer == 2'(l))) begin
                pend_cfg_d[l]   = '{en: cfg_en, bpp: cfg_bpp, trans_en: cfg_trans_en};
                pend_trans_d[l] = cfg_trans;
                pend_offs_d[l]  = cfg_offs;
            end
        end
        // Commit from the _d side so a write in the frame_start cycle goes straight through.
        act_cfg_d   = act_cfg_q;
        act_trans_d = act_trans_q;
        act_offs_d  = act_offs_q;
        if (frame_start) begin
            act_cfg_d   = pend_cfg_d;
            act_trans_d = pend_trans_d;
            act_offs_d  = pend_offs_d;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            pend_cfg_q   <= '{default: CFG_RESET};
            pend_trans_q <= '{default: '0};
            pend_offs_q  <= '{default: '0};
            act_cfg_q    <= '{default: CFG_RESET};
            act_trans_q  <= '{default: '0};
            act_offs_q   <= '{default: '0};
        end else begin
            pend_cfg_q   <= pend_cfg_d;
            pend_trans_q <= pend_trans_d;
            pend_offs_q  <= pend_offs_d;
            act_cfg_q    <= act_cfg_d;
            act_trans_q  <= act_trans_d;
            act_offs_q   <= act_offs_d;
        end
    end

    // ---------------- pix_id / paint delay to meet vram_dout ----------------
    logic [LAYERS*5-1:0] pix_id_dly;
    logic [LAYERS-1:0]   paint_dly;

    generate
        if (VRAM_LAT == 0) begin : g_nodly
            assign pix_id_dly = pix_id;
            assign paint_dly  = paint;
        end else begin : g_dly
            logic [LAYERS*5-1:0] id_sr_d [VRAM_LAT];
            logic [LAYERS*5-1:0] id_sr_q [VRAM_LAT];
            logic [LAYERS-1:0]   pt_sr_d [VRAM_LAT];
            logic [LAYERS-1:0]   pt_sr_q [VRAM_LAT];

            always_comb begin
                id_sr_d[0] = pix_id;
                pt_sr_d[0] = paint;
                for (int unsigned i = 1; i < VRAM_LAT; i++) begin
                    id_sr_d[i] = id_sr_q[i-1];
                    pt_sr_d[i] = pt_sr_q[i-1];
                end
            end

            always_ff @(posedge clk_pix) begin
                if (rst_pix) begin
                    id_sr_q <= '{default: '0};
                    pt_sr_q <= '{default: '0};
                end else begin
                    id_sr_q <= id_sr_d;
                    pt_sr_q <= pt_sr_d;
                end
            end

            assign pix_id_dly = id_sr_q[VRAM_LAT-1];
            assign paint_dly  = pt_sr_q[VRAM_LAT-1];
        end
    endgenerate

    // ---------------- Stage A: unpack + per-layer attributes ----------------
    // raw is registered inside the unpacker; the attributes it is judged with are
    // registered here in the same cycle so each pixel keeps its own config.
    logic [RAW_W-1:0]      raw          [LAYERS];
    logic [LAYERS-1:0]     sa_live_d;
    logic [LAYERS-1:0]     sa_live_q;
    logic [LAYERS-1:0]     sa_trans_en_d;
    logic [LAYERS-1:0]     sa_trans_en_q;
    logic [CIDX_ADDRW-1:0] sa_trans_d   [LAYERS];
    logic [CIDX_ADDRW-1:0] sa_trans_q   [LAYERS];
    logic [CIDX_ADDRW-1:0] sa_offs_d    [LAYERS];
    logic [CIDX_ADDRW-1:0] sa_offs_q    [LAYERS];

    generate
        for (genvar g = 0; g < LAYERS; g++) begin : g_unpack
            canv_pix_unpack #(
                .WORD (WORD)
            ) u_unpack (
                .clk    (clk_pix),
                .rst    (rst_pix),
                .word   (vram_dout[g*WORD +: WORD]),
                .pix_id (pix_id_dly[g*5 +: 5]),
                .bpp    (act_cfg_q[g].bpp),
                .raw    (raw[g])
            );
        end
    endgenerate

    always_comb begin
        for (int unsigned l = 0; l < LAYERS; l++) begin
            sa_live_d[l]     = act_cfg_q[l].en & paint_dly[l];
            sa_trans_en_d[l] = act_cfg_q[l].trans_en;
            sa_trans_d[l]    = act_trans_q[l];
            sa_offs_d[l]     = act_offs_q[l];
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            sa_live_q     <= '0;
            sa_trans_en_q <= '0;
            sa_trans_q    <= '{default: '0};
            sa_offs_q     <= '{default: '0};
        end else begin
            sa_live_q     <= sa_live_d;
            sa_trans_en_q <= sa_trans_en_d;
            sa_trans_q    <= sa_trans_d;
            sa_offs_q     <= sa_offs_d;
        end
    end

    // ---------------- Stage B: transparency, offset, priority ----------------
    logic [LAYERS-1:0]     opaque;
    logic [CIDX_ADDRW-1:0] idx [LAYERS];
    logic [CIDX_ADDRW-1:0] mix_cidx_d;
    logic [CIDX_ADDRW-1:0] mix_cidx_q;
    logic                  mix_paint_d;
    logic                  mix_paint_q;
    logic [1:0]            mix_layer_d;
    logic [1:0]            mix_layer_q;

    always_comb begin
        mix_cidx_d  = '0;
        mix_paint_d = 1'b0;
        mix_layer_d = '0;
        for (int unsigned l = 0; l < LAYERS; l++) begin
            // transparency is tested on the raw index, before the palette offset
            opaque[l] = sa_live_q[l] &
                        ~(sa_trans_en_q[l] & (CMP_W'(raw[l]) == CMP_W'(sa_trans_q[l])));
            idx[l]    = CIDX_ADDRW'(raw[l]) + sa_offs_q[l];
            if (opaque[l] && !mix_paint_d) begin
                mix_cidx_d  = idx[l];
                mix_paint_d = 1'b1;
                mix_layer_d = 2'(l);
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            mix_cidx_q  <= '0;
            mix_paint_q <= 1'b0;
            mix_layer_q <= '0;
        end else begin
            mix_cidx_q  <= mix_cidx_d;
            mix_paint_q <= mix_paint_d;
            mix_layer_q <= mix_layer_d;
        end
    end

    assign mix_cidx  = mix_cidx_q;
    assign mix_paint = mix_paint_q;
    assign mix_layer = mix_layer_q;

endmodule
